// File: rtl/cpu_irq_ctrl.sv
// cpu_irq_ctrl: fabric interrupt receiver for the CPU clock domain.
// Syncs IRQ lines, latches pending events, presents one at a time.
module cpu_irq_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               UserCLK,
  input  logic               resetn,
  input  logic               CONFIGURED,
  input  logic [NUM_IRQ-1:0] IRQ_top,
  input  logic               cfg_we,
  input  logic [NUM_IRQ-1:0] cfg_enable,
  input  logic [NUM_IRQ-1:0] cfg_edge,
  output logic               irq_req,
  output logic [IW-1:0]      irq_id,
  input  logic               irq_ack,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NUM_IRQ-1:0]     irq_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] cfg_sync;
  logic                   cfg_prev;
  logic [NUM_IRQ-1:0]     prev;
  logic [NUM_IRQ-1:0]     enable;
  logic [NUM_IRQ-1:0]     mode;

  logic               s_cfg;
  logic               cfg_fall;
  logic [NUM_IRQ-1:0] s_irq;
  logic [NUM_IRQ-1:0] set;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] cand;
  logic               win_vld;
  logic [IW-1:0]      win_id;
  logic               id_load;
  logic               ack_ok;

  assign s_cfg    = cfg_sync[SYNC_STAGES-1];
  assign cfg_fall = cfg_prev & ~s_cfg;
  assign s_irq    = s_cfg ? irq_sync[SYNC_STAGES-1] : '0;
  assign set      = (mode & s_irq & ~prev) | (~mode & s_irq);
  assign cand     = pending & enable;
  assign clr      = ack_ok ? (NUM_IRQ'(1) << irq_id) : '0;
  assign irq_req  = (state == REQ);

  // Synchroniser chains for the IRQ lines and the configured flag
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        irq_sync[k] <= '0;
      end
      cfg_sync <= '0;
    end else begin
      irq_sync[0] <= IRQ_top;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        irq_sync[k] <= irq_sync[k-1];
      end
      cfg_sync <= {cfg_sync[SYNC_STAGES-2:0], CONFIGURED};
    end
  end

  // Edge-detect history and configured-fall history
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      prev     <= '0;
      cfg_prev <= 1'b0;
    end else begin
      prev     <= s_irq;
      cfg_prev <= s_cfg;
    end
  end

  // Enable and mode registers
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      enable <= '0;
      mode   <= '0;
    end else if (cfg_we) begin
      enable <= cfg_enable;
      mode   <= cfg_edge;
    end
  end

  // Pending latch; set beats ack clear, config loss wipes it
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      pending <= '0;
    end else if (cfg_fall) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | set;
    end
  end

  // Fixed priority: lowest enabled pending index wins
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_id  = IW'(i);
      end
    end
  end

  // Request FSM next state and control strobes
  always_comb begin
    state_nxt = state;
    id_load   = 1'b0;
    ack_ok    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = REQ;
          id_load   = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_ok    = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cfg_fall) begin
      state_nxt = IDLE;
      id_load   = 1'b0;
      ack_ok    = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Requested id is captured on entry to REQ and held
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      irq_id <= '0;
    end else if (id_load) begin
      irq_id <= win_id;
    end
  end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// tb_cpu_irq_ctrl: directed and random checks of cpu_irq_ctrl
// against a cycle-level reference model.
module tb_cpu_irq_ctrl;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         cfgd;
  logic         ack;
  logic         we;
  logic [N-1:0] irq;
  logic [N-1:0] en_in;
  logic [N-1:0] edge_in;
  logic         req;
  logic [1:0]   id;
  logic [N-1:0] pend;

  int npass = 0;
  int ntot  = 0;

  cpu_irq_ctrl #(
    .NUM_IRQ(N),
    .SYNC_STAGES(S)
  ) dut (
    .UserCLK(clk),
    .resetn(resetn),
    .CONFIGURED(cfgd),
    .IRQ_top(irq),
    .cfg_we(we),
    .cfg_enable(en_in),
    .cfg_edge(edge_in),
    .irq_req(req),
    .irq_id(id),
    .irq_ack(ack),
    .pending(pend)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [N-1:0] h_irq [S];
  logic [S-1:0] h_cfg;
  logic [N-1:0] m_prev, m_pend, m_en, m_mode;
  logic         m_cfgp, m_req, m_gap;
  int           m_id;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic m_reset();
    for (int k = 0; k < S; k++) h_irq[k] = '0;
    h_cfg  = '0;
    m_prev = '0;
    m_pend = '0;
    m_en   = '0;
    m_mode = '0;
    m_cfgp = 1'b0;
    m_req  = 1'b0;
    m_gap  = 1'b0;
    m_id   = 0;
  endtask

  // one clock edge of the reference behaviour, using pre-edge inputs
  task automatic m_step();
    logic [N-1:0] si;
    logic [N-1:0] setv;
    logic         sc;
    int           win;
    sc   = h_cfg[S-1];
    si   = sc ? h_irq[S-1] : '0;
    setv = '0;
    for (int i = 0; i < N; i++)
      setv[i] = m_mode[i] ? (si[i] && !m_prev[i]) : si[i];
    win = -1;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && m_en[i]) win = i;
    if (m_cfgp && !sc) begin
      m_pend = '0;
      m_req  = 1'b0;
      m_gap  = 1'b0;
    end else begin
      if (m_req) begin
        if (ack) begin
          m_pend[m_id] = 1'b0;
          m_req = 1'b0;
          m_gap = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (win >= 0) begin
        m_req = 1'b1;
        m_id  = win;
      end
      m_pend = m_pend | setv;
    end
    if (we) begin
      m_en   = en_in;
      m_mode = edge_in;
    end
    m_prev = si;
    m_cfgp = sc;
    for (int k = S - 1; k > 0; k--) h_irq[k] = h_irq[k-1];
    h_irq[0] = irq;
    h_cfg    = {h_cfg[S-2:0], cfgd};
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    chk("req", req, m_req);
    chk("pend", pend, m_pend);
    if (m_req) chk("id", id, m_id);
  endtask

  task automatic drain();
    repeat (14) begin
      ack = m_req;
      cyc();
    end
    ack = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfgd = 1'b0; ack = 1'b0; we = 1'b0;
    irq = '0; en_in = '0; edge_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req, 0);
    chk("rst_pend", pend, 0);
    chk("rst_id", id, 0);
    @(negedge clk);
    resetn = 1'b1;

    // level line 2: 4-edge latency, ack, gap, re-request
    cfgd = 1'b1; we = 1'b1; en_in = 4'hF; edge_in = 4'h0;
    cyc();
    we = 1'b0;
    repeat (3) cyc();
    irq = 4'b0100;
    repeat (3) cyc();
    chk("t1_early", req, 0);
    cyc();
    chk("t1_req", req, 1);
    chk("t1_id", id, 2);
    ack = 1'b1; cyc(); ack = 1'b0;
    chk("t1_gap", req, 0);
    repeat (2) cyc();
    chk("t1_rereq", req, 1);
    chk("t1_reid", id, 2);
    irq = '0;
    drain();

    // edge mode: three pulses merge into one request
    we = 1'b1; en_in = 4'hF; edge_in = 4'hF;
    cyc();
    we = 1'b0;
    for (int p = 0; p < 3; p++) begin
      irq = 4'b0010; repeat (2) cyc();
      irq = 4'b0000; repeat (2) cyc();
    end
    chk("t2_req", req, 1);
    chk("t2_id", id, 1);
    chk("t2_pend", pend, 4'b0010);
    ack = 1'b1; cyc(); ack = 1'b0;
    repeat (6) cyc();
    chk("t2_noreq", req, 0);
    chk("t2_clr", pend, 0);

    // frozen id and priority order 1, 0, 3
    irq = 4'b1010; repeat (2) cyc();
    irq = 4'b0000; repeat (2) cyc();
    chk("t3_id1", id, 1);
    chk("t3_pend", pend, 4'b1010);
    irq = 4'b0001; repeat (2) cyc();
    irq = 4'b0000; repeat (2) cyc();
    chk("t3_hold", id, 1);
    chk("t3_pend2", pend, 4'b1011);
    ack = 1'b1; cyc(); ack = 1'b0;
    repeat (2) cyc();
    chk("t3_req0", req, 1);
    chk("t3_id0", id, 0);
    ack = 1'b1; cyc(); ack = 1'b0;
    repeat (2) cyc();
    chk("t3_req3", req, 1);
    chk("t3_id3", id, 3);
    ack = 1'b1; cyc(); ack = 1'b0;
    repeat (3) cyc();
    chk("t3_done", pend, 0);

    // disabled lines latch but never request
    we = 1'b1; en_in = 4'h0; edge_in = 4'h0;
    cyc();
    we = 1'b0;
    irq = 4'hF;
    repeat (5) cyc();
    chk("t4_pend", pend, 4'hF);
    chk("t4_noreq", req, 0);
    we = 1'b1; en_in = 4'b1000;
    cyc();
    we = 1'b0;
    cyc();
    chk("t4_req", req, 1);
    chk("t4_id", id, 3);

    // configured loss mid-request
    we = 1'b1; en_in = 4'hF;
    cyc();
    we = 1'b0;
    cfgd = 1'b0;
    repeat (3) cyc();
    chk("t5_req", req, 0);
    chk("t5_pend", pend, 0);
    repeat (6) cyc();
    chk("t5_hold", pend, 0);
    irq = '0; cfgd = 1'b1;
    repeat (4) cyc();

    // stray ack in idle leaves latched pending alone
    we = 1'b1; en_in = 4'h0;
    cyc();
    we = 1'b0;
    irq = 4'b0001; repeat (4) cyc();
    irq = 4'b0000; repeat (3) cyc();
    ack = 1'b1; repeat (2) cyc(); ack = 1'b0;
    chk("t6_stray", pend, 4'b0001);
    chk("t6_idle", req, 0);

    // asynchronous reset while requesting
    we = 1'b1; en_in = 4'hF;
    cyc();
    we = 1'b0;
    cyc();
    chk("t6_req", req, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async", req, 0);
    chk("t6_rpend", pend, 0);
    m_reset();
    @(negedge clk);
    resetn = 1'b1;

    // randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) irq = N'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      we  = ($urandom_range(0, 11) == 0);
      en_in   = N'($urandom);
      edge_in = N'($urandom);
      if ($urandom_range(0, 49) == 0) cfgd = ~cfgd;
      if (c < 10) cfgd = 1'b1;
      cyc();
    end
    ack = 1'b0; we = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
